// File: rtl/tanimoto_pkg.sv
// tanimoto_pkg: shared defaults, ID-pair geometry helpers and packer FSM encoding
//   BUS_WIDTH_DEF / VEC_ID_WIDTH_DEF : default output word and vector ID widths
//   pair_width()     : bits in one ID pair
//   pairs_per_word() : ID pairs packed into one output word
//   state_t          : id_pair_packer FSM states
package tanimoto_pkg;

    localparam int BUS_WIDTH_DEF    = 128;
    localparam int VEC_ID_WIDTH_DEF = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        TRAILER = 1'b1
    } state_t;

    function automatic int pair_width(input int vec_id_w);
        return 2 * vec_id_w;
    endfunction

    function automatic int pairs_per_word(input int bus_w, input int vec_id_w);
        return bus_w / (2 * vec_id_w);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single AXI-Stream output register (tdata/tkeep/tlast with valid/ready)
//   clk, rstn          : clock, asynchronous active-low reset
//   load               : capture d_* into the register (only when free)
//   d_data/d_keep/d_last : word to capture
//   tready             : downstream ready
//   tdata/tkeep/tlast/tvalid : registered output stream
//   free               : register empty or being drained this cycle
module axis_out_reg #(
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [DATA_W-1:0]     d_data,
    input  logic [DATA_W/8-1:0]   d_keep,
    input  logic                  d_last,
    input  logic                  tready,
    output logic [DATA_W-1:0]     tdata,
    output logic [DATA_W/8-1:0]   tkeep,
    output logic                  tlast,
    output logic                  tvalid,
    output logic                  free
);

    assign free = !tvalid || tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
            tvalid <= 1'b0;
        end else if (load) begin
            tdata  <= d_data;
            tkeep  <= d_keep;
            tlast  <= d_last;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/id_pair_packer.sv
// id_pair_packer: packs ID pairs from the Tanimoto core into BUS_WIDTH output words
//   ap_clk, ap_rstn          : clock, asynchronous active-low reset
//   S_AXIS_ID_PAIR_*         : input pair stream (tlast closes a run)
//   M_AXIS_DATA_*            : packed output stream, slot 0 at the LSBs
//   pair_count               : pairs accepted in the current/last run (saturating)
// Build option: define PAIR_COUNT_TRAILER_EN to append a pair_count trailer word
// after the last data word of each run (tlast then moves onto the trailer).
module id_pair_packer
    import tanimoto_pkg::*;
#(
    parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
    parameter int VEC_ID_WIDTH = VEC_ID_WIDTH_DEF
) (
    input  logic                      ap_clk,
    input  logic                      ap_rstn,
    input  logic [2*VEC_ID_WIDTH-1:0] S_AXIS_ID_PAIR_tdata,
    input  logic                      S_AXIS_ID_PAIR_tvalid,
    input  logic                      S_AXIS_ID_PAIR_tlast,
    output logic                      S_AXIS_ID_PAIR_tready,
    output logic [BUS_WIDTH-1:0]      M_AXIS_DATA_tdata,
    output logic                      M_AXIS_DATA_tvalid,
    output logic [BUS_WIDTH/8-1:0]    M_AXIS_DATA_tkeep,
    output logic                      M_AXIS_DATA_tlast,
    input  logic                      M_AXIS_DATA_tready,
    output logic [31:0]               pair_count
);

    localparam int PAIR_W = pair_width(VEC_ID_WIDTH);
    localparam int PPW    = pairs_per_word(BUS_WIDTH, VEC_ID_WIDTH);
    localparam int KEEP_W = BUS_WIDTH / 8;
    localparam int SLOT_W = PPW > 1 ? $clog2(PPW) : 1;

    state_t               state, state_nx;
    logic [BUS_WIDTH-1:0] acc, word, ld_data;
    logic [KEEP_W-1:0]    pend_keep, keep_new, ld_keep;
    logic [SLOT_W-1:0]    slot;
    logic                 pending, pend_last, run_done, rdy_en;
    logic                 hs, complete, new_pend, out_free, load, ld_final, ld_tlast;

    assign hs       = S_AXIS_ID_PAIR_tvalid && S_AXIS_ID_PAIR_tready;
    assign complete = hs && (slot == SLOT_W'(PPW - 1) || S_AXIS_ID_PAIR_tlast);
    // a completed word parks in acc when the output register cannot take it
    assign new_pend = complete && (pending || !out_free);

`ifdef PAIR_COUNT_TRAILER_EN
    // also hold off while the run-final word is parked so the next run
    // cannot disturb pair_count before the trailer is built
    assign S_AXIS_ID_PAIR_tready = rdy_en && state == COLLECT && !(pending && !out_free)
                                   && !(pending && pend_last);
`else
    assign S_AXIS_ID_PAIR_tready = rdy_en && state == COLLECT && !(pending && !out_free);
`endif

    // a pair accepted while a parked word drains starts a fresh word
    always_comb begin
        word = pending ? '0 : acc;
        word[int'(slot)*PAIR_W +: PAIR_W] = S_AXIS_ID_PAIR_tdata;
        for (int b = 0; b < KEEP_W; b++)
            keep_new[b] = b * 8 < (int'(slot) + 1) * PAIR_W;
    end

    always_comb begin
        load     = 1'b0;
        ld_data  = acc;
        ld_keep  = pend_keep;
        ld_final = pend_last;
        ld_tlast = 1'b0;
        state_nx = state;
        if (state == TRAILER) begin
            load          = out_free;
            ld_data       = '0;
            ld_data[31:0] = pair_count;
            ld_keep       = '1;
            ld_final      = 1'b0;
            ld_tlast      = 1'b1;
            if (out_free)
                state_nx = COLLECT;
        end else if (pending) begin
            load = out_free;
        end else begin
            load     = complete && out_free;
            ld_data  = word;
            ld_keep  = keep_new;
            ld_final = S_AXIS_ID_PAIR_tlast;
        end
`ifdef PAIR_COUNT_TRAILER_EN
        if (state == COLLECT && load && ld_final)
            state_nx = TRAILER;
`else
        if (state == COLLECT)
            ld_tlast = ld_final;
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            state      <= COLLECT;
            acc        <= '0;
            pend_keep  <= '0;
            slot       <= '0;
            pending    <= 1'b0;
            pend_last  <= 1'b0;
            run_done   <= 1'b1;
            rdy_en     <= 1'b0;
            pair_count <= '0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
            if (hs) begin
                pair_count <= run_done ? 32'd1 : (&pair_count ? pair_count : pair_count + 32'd1);
                run_done   <= S_AXIS_ID_PAIR_tlast;
                if (complete) begin
                    slot      <= '0;
                    pending   <= new_pend;
                    acc       <= new_pend ? word : '0;
                    pend_keep <= keep_new;
                    pend_last <= S_AXIS_ID_PAIR_tlast;
                end else begin
                    slot    <= slot + 1'b1;
                    pending <= 1'b0;
                    acc     <= word;
                end
            end else if (pending && load) begin
                pending <= 1'b0;
                acc     <= '0;
            end
        end
    end

    axis_out_reg #(
        .DATA_W (BUS_WIDTH)
    ) u_out (
        .clk    (ap_clk),
        .rstn   (ap_rstn),
        .load   (load),
        .d_data (ld_data),
        .d_keep (ld_keep),
        .d_last (ld_tlast),
        .tready (M_AXIS_DATA_tready),
        .tdata  (M_AXIS_DATA_tdata),
        .tkeep  (M_AXIS_DATA_tkeep),
        .tlast  (M_AXIS_DATA_tlast),
        .tvalid (M_AXIS_DATA_tvalid),
        .free   (out_free)
    );

endmodule
